// File: rtl/mac_frame_host_if.sv
// Word-level command/result streams between the system side and mac_frame_host.
// master drives commands and consumes results; slave is the host block.
interface mac_frame_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_weight;
  logic [31:0] cmd_bias;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  modport master (
    output cmd_valid, cmd_weight, cmd_bias, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_weight, cmd_bias, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_frame_host.sv
// Host-side initiator for the byte-serial MAC: 4-beat frames, result FIFO.
// Optional MACHOST_STATS_EN adds frames_ok / frames_idle counters.
module mac_frame_host #(
  parameter int RST_CYCLES = 2,
  parameter int RES_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [6:0]       act_i,
  mac_frame_host_if.slave  bus,
  output logic             busy,
  output logic             mac_rst_n,
  output logic [7:0]       mac_ui,
  output logic [7:0]       mac_uio,
  input  logic [7:0]       mac_uo,
  input  logic [7:0]       mac_uio_out
`ifdef MACHOST_STATS_EN
  ,
  output logic [15:0]      frames_ok,
  output logic [15:0]      frames_idle
`endif
);

  localparam int CW = $clog2(RES_DEPTH);
  localparam int LW = $clog2(RST_CYCLES) + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(RES_DEPTH);
  localparam logic [LW-1:0] LD_LAST = LW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, PRIME, RUN
  } state_t;

  state_t       state;
  logic [6:0]   act;
  logic [LW-1:0] ld_cnt;
  logic [1:0]   beat;
  logic [7:0]   w_q;
  logic [31:0]  b_q;
  logic         tag;
  logic         pend;
  logic [23:0]  cap;

  logic [31:0]  mem [RES_DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW:0]  count;

  logic         run_b0;
  logic [CW+1:0] inflight;
  logic         accept;
  logic         load_ok;
  logic         push;
  logic         pop;
  logic [7:0]   cur_w;
  logic [31:0]  cur_b;

  // Probe-only pin; reduced so it is visibly consumed.
  logic unused_probe;
  assign unused_probe = ^mac_uio_out;

  assign run_b0   = (state == RUN) && (beat == 2'd0);
  assign inflight = {1'b0, count} + {{(CW+1){1'b0}}, pend};
  assign accept   = run_b0 && bus.cmd_valid && (inflight < DEPTH_W);
  assign load_ok  = load && ((state == IDLE) ||
                    (run_b0 && !pend && !accept));
  assign push     = (state == RUN) && (beat == 2'd3) && pend;
  assign pop      = bus.res_valid && bus.res_ready;

  assign bus.cmd_ready = accept;
  assign bus.res_valid = (count != '0);
  assign bus.res_data  = mem[rd_ptr];
  assign busy          = (state != IDLE);

  // Beat 0 forwards the command being accepted; later beats replay the latch.
  assign cur_w = (beat == 2'd0) ? (accept ? bus.cmd_weight : 8'h00) : w_q;
  assign cur_b = (beat == 2'd0) ? (accept ? bus.cmd_bias : 32'h0) : b_q;

  always_comb begin
    mac_rst_n = 1'b0;
    mac_ui    = 8'h00;
    mac_uio   = 8'h00;
    unique case (state)
      IDLE: ;
      LOAD: mac_ui = {1'b0, act};
      PRIME: mac_rst_n = 1'b1;
      RUN: begin
        mac_rst_n = 1'b1;
        mac_ui    = cur_w;
        unique case (beat)
          2'd0: mac_uio = cur_b[15:8];
          2'd1: mac_uio = cur_b[7:0];
          2'd2: mac_uio = cur_b[31:24];
          2'd3: mac_uio = cur_b[23:16];
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      act    <= '0;
      ld_cnt <= '0;
      beat   <= '0;
      w_q    <= '0;
      b_q    <= '0;
      tag    <= 1'b0;
      pend   <= 1'b0;
      cap    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_ok) begin
            act    <= act_i;
            ld_cnt <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (ld_cnt == LD_LAST) state <= PRIME;
          else ld_cnt <= ld_cnt + 1'b1;
        end
        PRIME: begin
          state <= RUN;
          beat  <= '0;
          tag   <= 1'b0;
          pend  <= 1'b0;
        end
        RUN: begin
          beat <= beat + 1'b1;
          cap  <= {cap[15:0], mac_uo};
          if (beat == 2'd0) begin
            w_q <= cur_w;
            b_q <= cur_b;
            tag <= accept;
          end
          if (beat == 2'd3) pend <= tag;
          if (load_ok) begin
            act    <= act_i;
            ld_cnt <= '0;
            beat   <= '0;
            state  <= LOAD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cap, mac_uo};
  end

`ifdef MACHOST_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || load_ok) begin
      frames_ok   <= '0;
      frames_idle <= '0;
    end else begin
      if (push) frames_ok <= frames_ok + 1'b1;
      if (run_b0 && !accept) frames_idle <= frames_idle + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_frame_host.sv
// Bench for mac_frame_host: behavioural MAC pin model plus result scoreboard.
// Expected results are hand-computed bias + act*weight constants.
module tb_mac_frame_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [6:0] act_i;
  logic       busy;
  logic       mac_rst_n;
  logic [7:0] mac_ui;
  logic [7:0] mac_uio;
  logic [7:0] mac_uo;
  logic [7:0] mac_uio_out;
`ifdef MACHOST_STATS_EN
  logic [15:0] frames_ok;
  logic [15:0] frames_idle;
`endif

  mac_frame_host_if bus ();

  mac_frame_host #(.RST_CYCLES(2), .RES_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .act_i       (act_i),
    .bus         (bus.slave),
    .busy        (busy),
    .mac_rst_n   (mac_rst_n),
    .mac_ui      (mac_ui),
    .mac_uio     (mac_uio),
    .mac_uo      (mac_uo),
    .mac_uio_out (mac_uio_out)
`ifdef MACHOST_STATS_EN
    ,
    .frames_ok   (frames_ok),
    .frames_idle (frames_idle)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // MAC pin model: activation loaded in reset, one product per 4-beat frame
  logic [6:0]  m_act;
  logic        m_primed;
  logic [1:0]  m_beat;
  logic [7:0]  m_w;
  logic [31:0] m_b;
  logic [31:0] m_res;

  always @(posedge clk) begin
    if (!mac_rst_n) begin
      m_act    <= mac_ui[6:0];
      m_primed <= 1'b0;
      m_beat   <= 2'd0;
      m_res    <= 32'h0;
    end else if (!m_primed) begin
      m_primed <= 1'b1;
    end else begin
      m_beat <= m_beat + 2'd1;
      case (m_beat)
        2'd0: begin m_w <= mac_ui; m_b[15:8] <= mac_uio; end
        2'd1: m_b[7:0] <= mac_uio;
        2'd2: m_b[31:24] <= mac_uio;
        2'd3: m_res <= {m_b[31:24], mac_uio, m_b[15:0]}
                       + 32'(m_act) * 32'(m_w);
      endcase
    end
  end

  always_comb begin
    mac_uo = 8'h00;
    if (m_primed && mac_rst_n)
      case (m_beat)
        2'd0: mac_uo = m_res[31:24];
        2'd1: mac_uo = m_res[23:16];
        2'd2: mac_uo = m_res[15:8];
        2'd3: mac_uo = m_res[7:0];
      endcase
  end

  typedef struct {
    logic [31:0] d;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];

  // Monitor: pop and compare on each handshake
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      exp_t e;
      n_pop++;
      if (sb.size() == 0) begin
        chk("unexpected_res", bus.res_data, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("res_data", bus.res_data, e.d);
        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd8);
      end
    end
  end

  // Bias byte order on the MAC pins for the marker command
  initial begin
    logic [7:0] ord [4];
    ord[0] = 8'hC3; ord[1] = 8'hD4; ord[2] = 8'hA1; ord[3] = 8'hB2;
    forever begin
      @(negedge clk); #2;
      if (bus.cmd_valid && bus.cmd_ready &&
          bus.cmd_bias == 32'hA1B2C3D4) begin
        for (int k = 0; k < 4; k++) begin
          if (k > 0) begin @(negedge clk); #2; end
          chk("uio_beat", 32'(mac_uio), 32'(ord[k]));
          chk("ui_beat", 32'(mac_ui), 32'h0000_00FF);
        end
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic [31:0] b,
                      input logic [31:0] e, input bit lat);
    int n = 0;
    exp_t x;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_weight = w;
    bus.cmd_bias   = b;
    #1;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 32'(n), 32'd0);
    end else begin
      x.d = e; x.acc = cyc; x.lat = lat;
      sb.push_back(x);
      last_acc = cyc;
      n_acc++;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [6:0] a);
    @(posedge clk); #1;
    load = 1'b1; act_i = a;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  logic [7:0]  bw [6];
  logic [31:0] bb [6];
  logic [31:0] be [6];
  logic [31:0] pe [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int prev;
    bw[0] = 8'h01; bb[0] = 32'h0000_0000; be[0] = 32'h0000_0003;
    bw[1] = 8'h02; bb[1] = 32'h0000_0064; be[1] = 32'h0000_006A;
    bw[2] = 8'h10; bb[2] = 32'h0000_1000; be[2] = 32'h0000_1030;
    bw[3] = 8'hFF; bb[3] = 32'hA1B2C3D4; be[3] = 32'hA1B2C6D1;
    bw[4] = 8'h07; bb[4] = 32'hFFFF_FFF0; be[4] = 32'h0000_0005;
    bw[5] = 8'h80; bb[5] = 32'h1234_5678; be[5] = 32'h1234_57F8;
    pe[0] = 32'h103; pe[1] = 32'h206; pe[2] = 32'h309;
    pe[3] = 32'h40C; pe[4] = 32'h50F; pe[5] = 32'h612;

    rst = 1'b1; load = 1'b0; act_i = '0;
    bus.cmd_valid = 1'b0; bus.cmd_weight = '0; bus.cmd_bias = '0;
    bus.res_ready = 1'b1; mac_uio_out = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_mac_rst_n", 32'(mac_rst_n), 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ui", 32'(mac_ui), 32'd0);
      chk("rst_uio", 32'(mac_uio), 32'd0);
    end

    do_load(7'd3);
    chk("busy_after_load", 32'(busy), 32'd1);
    base = n_pop;
    send(8'd5, 32'h0000_0010, 32'h0000_001F, 1'b1);
    drain();
    repeat (16) @(posedge clk);
    chk("single_result", 32'(n_pop - base), 32'd1);

    base = n_pop;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send(bw[i], bb[i], be[i], 1'b1);
      if (i > 0) chk("b2b_spacing", 32'(last_acc - prev), 32'd4);
      prev = last_acc;
    end
    drain();
    chk("b2b_count", 32'(n_pop - base), 32'd6);

    @(posedge clk); #1 bus.res_ready = 1'b0;
    base = n_acc;
    fork
      for (int i = 0; i < 6; i++) send(8'(i + 1), 32'(256 * (i + 1)), pe[i], 1'b0);
    join_none
    repeat (40) @(posedge clk);
    chk("bp_accepts", 32'(n_acc - base), 32'd4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_zero_ui", 32'(mac_ui), 32'd0);
      chk("bp_zero_uio", 32'(mac_uio), 32'd0);
    end
    chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
    base = n_pop;
    @(posedge clk); #1 bus.res_ready = 1'b1;
    wait fork;
    drain();
    repeat (16) @(posedge clk);
    chk("bp_count", 32'(n_pop - base), 32'd6);

    @(posedge clk); #1 bus.res_ready = 1'b0;
    send(8'd2, 32'h0, 32'h6, 1'b0);
    send(8'd3, 32'h0, 32'h9, 1'b0);
    begin
      int n = 0;
      while (n < 100 && !((cyc - last_acc) >= 10 &&
             (cyc - last_acc) % 4 == 2)) begin
        @(negedge clk); n++;
      end
    end
    chk("pre_rst_res_valid", 32'(bus.res_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_mid_mac_rst_n", 32'(mac_rst_n), 32'd0);
    bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_fifo_empty", 32'(bus.res_valid), 32'd0);

    do_load(7'h7F);
    base = n_pop;
    send(8'hFF, 32'hFFFF_FFFF, 32'h0000_7E80, 1'b1);
    drain();
    repeat (16) @(posedge clk);
    chk("wrap_count", 32'(n_pop - base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
